time_rom_arbiter: RTL and testbench
===================================

TIME_ROM_ARBITER -- requirements
Module: time_rom_arbiter

Interface
REQ-001 Parameter DEPTH, default 272: number of valid ROM words (34x8 sprite).
REQ-002 Parameter AW, default 9: address width.
REQ-003 Parameter DW, default 4: palette-index data width.
REQ-004 Clk  input  1  system clock; all logic on posedge Clk.
REQ-005 Reset_n  input  1  reset, synchronous, active-low.
REQ-006 req0 / req1  input  1  read request from requester 0 (pixel draw) and requester 1 (timer-bar renderer); held until granted.
REQ-007 addr0 / addr1  input  AW  requested ROM address; stable while reqN is high.
REQ-008 grant0 / grant1  output  1  one-cycle acceptance of the current request.
REQ-009 rvalid0 / rvalid1  output  1  read data valid for that requester.
REQ-010 rdata0 / rdata1  output  DW  read data; 0 when rvalidN is low.
REQ-011 rom_addr  output  AW  address to the single-port sprite ROM.
REQ-012 rom_data  input  DW  ROM data; valid one cycle after rom_addr is sampled.
REQ-013 err_oob  output  1  sticky flag: a granted address was >= DEPTH.
REQ-014 gcnt0 / gcnt1  output  16  saturating grant counters.

Function
REQ-015 At most one of grant0/grant1 SHALL be high in any cycle; one grant per cycle maximum.
REQ-016 Grant SHALL be combinational from reqN and the arbitration state in the same cycle the request is seen.
REQ-017 Only req0 high -> grant0; only req1 high -> grant1; neither -> no grant, rom_addr = 0.
REQ-018 In a grant cycle, rom_addr SHALL equal the granted address if < DEPTH, else 0.
REQ-019 A grant in cycle t SHALL produce rvalidN high for exactly cycle t+1 with rdataN = rom_data (fixed one-cycle latency), for the same requester N.
REQ-020 A granted out-of-range address SHALL still produce rvalidN at t+1, with rdataN = 0, and SHALL set err_oob from t+1 until reset.
REQ-021 Back-to-back grants SHALL be supported every cycle; the return-tag register (valid, id, oob) SHALL be reloaded each cycle.
REQ-022 A requester that keeps reqN high after its grant SHALL be treated as issuing a new request.
REQ-023 gcntN SHALL increment by 1 on each grantN and saturate at 16'hFFFF.
REQ-024 Arbitration state: a one-bit last-granted pointer, updated on every grant to the granted id.

Reset
REQ-025 While Reset_n is low at a posedge: the return tag clears, the pointer resets to 1 (requester 0 wins next tie), err_oob clears, and gcnt0 and gcnt1 clear.
REQ-026 During reset, grants, rvalid, rdata and rom_addr SHALL all be 0, and incoming requests are ignored.
REQ-027 Reset asserted in cycle t+1 after a grant in cycle t SHALL suppress that rvalid; no response is delivered after reset.

Configuration
REQ-028 Macro TIME_ROM_ARB_RR_EN defined: when both requests are high, the requester not equal to the pointer SHALL win (round-robin, alternating).
REQ-029 Macro TIME_ROM_ARB_RR_EN undefined: when both requests are high, requester 0 SHALL always win (fixed priority); the pointer is still maintained but unused.

Verification
REQ-030 Reset, then req0=1 with addr0=5 for one cycle -> grant0 in the same cycle, rom_addr=5, rvalid0=1 next cycle with rdata0=mem[5], gcnt0=1.
REQ-031 req0 and req1 both held for 4 cycles with RR_EN defined -> grants 0,1,0,1; with RR_EN undefined -> grants 0,0,0,0 and grant1 never asserts.
REQ-032 req1=1 with addr1=300 -> grant1, rom_addr=0, next cycle rvalid1=1, rdata1=0, err_oob=1 and stays 1 until Reset_n=0.
REQ-033 Alternating grants on consecutive cycles to addresses 0 and 271 -> each rvalid is routed to the correct requester one cycle later with the matching ROM word.
REQ-034 Grant in cycle t, Reset_n=0 in cycle t+1 -> rvalid0 and rvalid1 are 0 at t+1 and after, all counters are 0, and err_oob is 0.
REQ-035 Force gcnt0 near 16'hFFFF (70000 grants) -> gcnt0 holds at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/time_rom_arbiter.sv
// time_rom_arbiter: two-requester arbiter in front of a single-port sprite ROM.
// Requester 0 draws pixels and requester 1 renders the timer bar. Grants are
// combinational. Read data returns one cycle after the grant. A return tag
// (valid, id, oob) routes that data back to the requester that was granted.
// Optional feature: define TIME_ROM_ARB_RR_EN for round-robin tie-breaking.
// When it is left undefined, requester 0 always wins a tie (fixed priority).
module time_rom_arbiter #(
    parameter int DEPTH = 272,
    parameter int AW    = 9,
    parameter int DW    = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          grant0,
    output logic          grant1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          err_oob,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1
);

    // Saturating 16-bit increment used by both grant counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    logic          ptr_r;        // id of the last granted requester
    logic          tag_valid_r;  // a grant was issued in the previous cycle
    logic          tag_id_r;     // requester that owns the returning data
    logic          tag_oob_r;    // the returning grant was out of range
    logic          err_oob_r;
    logic [15:0]   gcnt0_r;
    logic [15:0]   gcnt1_r;

    logic          grant0_s;
    logic          grant1_s;
    logic          gnt_any_s;
    logic          gnt_oob_s;
    logic [AW-1:0] gnt_addr_s;

    // Arbitration: pick at most one requester this cycle. Nothing is granted in reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!Reset_n) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0 && req1) begin
`ifdef TIME_ROM_ARB_RR_EN
            // The requester that was not granted last time wins the tie.
            grant0_s = ptr_r;
            grant1_s = ~ptr_r;
`else
            // Fixed priority: the pointer is still tracked but cannot steer this choice.
            grant0_s = 1'b1;
            grant1_s = ptr_r & 1'b0;
`endif
        end else if (req0) begin
            grant0_s = 1'b1;
        end else if (req1) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Address path: select the granted address. An out-of-range address drives address 0 to the ROM.
    always_comb begin
        gnt_any_s = grant0_s | grant1_s;
        if (grant1_s) begin
            gnt_addr_s = addr1;
        end else begin
            gnt_addr_s = addr0;
        end
        gnt_oob_s = gnt_any_s && (32'(gnt_addr_s) >= DEPTH);
        if (gnt_any_s && !gnt_oob_s) begin
            rom_addr = gnt_addr_s;
        end else begin
            rom_addr = {AW{1'b0}};
        end
    end

    // State: return tag reloaded every cycle, last-grant pointer, sticky error, grant counters.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr_r       <= 1'b1;
            tag_valid_r <= 1'b0;
            tag_id_r    <= 1'b0;
            tag_oob_r   <= 1'b0;
            err_oob_r   <= 1'b0;
            gcnt0_r     <= 16'h0000;
            gcnt1_r     <= 16'h0000;
        end else begin
            tag_valid_r <= gnt_any_s;
            tag_id_r    <= grant1_s;
            tag_oob_r   <= gnt_oob_s;
            if (gnt_any_s) begin
                ptr_r <= grant1_s;
            end else begin
                ptr_r <= ptr_r;
            end
            err_oob_r <= err_oob_r | gnt_oob_s;
            if (grant0_s) begin
                gcnt0_r <= sat_inc16(gcnt0_r);
            end else begin
                gcnt0_r <= gcnt0_r;
            end
            if (grant1_s) begin
                gcnt1_r <= sat_inc16(gcnt1_r);
            end else begin
                gcnt1_r <= gcnt1_r;
            end
        end
    end

    // Output steering: route ROM data to the tagged requester. All outputs are held at 0 during reset.
    always_comb begin
        grant0  = grant0_s;
        grant1  = grant1_s;
        rvalid0 = Reset_n & tag_valid_r & ~tag_id_r;
        rvalid1 = Reset_n & tag_valid_r & tag_id_r;
        if (rvalid0 && !tag_oob_r) begin
            rdata0 = rom_data;
        end else begin
            rdata0 = {DW{1'b0}};
        end
        if (rvalid1 && !tag_oob_r) begin
            rdata1 = rom_data;
        end else begin
            rdata1 = {DW{1'b0}};
        end
        if (Reset_n) begin
            err_oob = err_oob_r;
            gcnt0   = gcnt0_r;
            gcnt1   = gcnt1_r;
        end else begin
            err_oob = 1'b0;
            gcnt0   = 16'h0000;
            gcnt1   = 16'h0000;
        end
    end

endmodule

// File: tb/tb_time_rom_arbiter.sv
// Testbench for time_rom_arbiter. It runs directed scenarios, then random
// traffic, then a counter saturation run. A cycle-level reference model of
// the arbitration rules supplies every expected value.
// TIME_ROM_ARB_RR_EN selects the tie-break rule used by the model.
module tb_time_rom_arbiter;
    localparam int DEPTH = 272;
    localparam int AW    = 9;
    localparam int DW    = 4;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          grant0, grant1, rvalid0, rvalid1, err_oob;
    logic [DW-1:0] rdata0, rdata1, rom_data;
    logic [AW-1:0] rom_addr;
    logic [15:0]   gcnt0, gcnt1;

    time_rom_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk(clk), .Reset_n(Reset_n), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .grant0(grant0), .grant1(grant1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .rom_addr(rom_addr), .rom_data(rom_data), .err_oob(err_oob),
        .gcnt0(gcnt0), .gcnt1(gcnt1)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents. The ROM has a one-cycle read latency.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) rom_data <= mem[rom_addr];

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    int m_last = 1;
    int m_pend_valid = 0, m_pend_id = 0, m_pend_addr = 0;
    int m_err = 0;
    int m_cnt0 = 0, m_cnt1 = 0;
    int m_g0 = 0, m_g1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs mid-cycle, then advance the model at the clock edge.
    task automatic step(input logic rst, input logic r0, input logic r1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int w, ea, e_rd;
        Reset_n = rst; req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
        #2;
        w = -1;
        if (rst) begin
            if (r0 && r1) begin
`ifdef TIME_ROM_ARB_RR_EN
                w = (m_last == 1) ? 0 : 1;
`else
                w = 0;
`endif
            end else if (r0) w = 0;
            else if (r1) w = 1;
        end
        ea = (w == 1) ? int'(a1) : int'(a0);
        e_rd = 0;
        if (m_pend_valid != 0 && m_pend_addr < DEPTH) e_rd = int'(mem[m_pend_addr]);
        chk("grant0", 32'(grant0), 32'(w == 0));
        chk("grant1", 32'(grant1), 32'(w == 1));
        chk("rom_addr", 32'(rom_addr), (w >= 0 && ea < DEPTH) ? 32'(ea) : 32'd0);
        chk("rvalid0", 32'(rvalid0), 32'(rst && m_pend_valid != 0 && m_pend_id == 0));
        chk("rvalid1", 32'(rvalid1), 32'(rst && m_pend_valid != 0 && m_pend_id == 1));
        chk("rdata0", 32'(rdata0), (rst && m_pend_valid != 0 && m_pend_id == 0) ? 32'(e_rd) : 32'd0);
        chk("rdata1", 32'(rdata1), (rst && m_pend_valid != 0 && m_pend_id == 1) ? 32'(e_rd) : 32'd0);
        chk("err_oob", 32'(err_oob), rst ? 32'(m_err) : 32'd0);
        chk("gcnt0", 32'(gcnt0), rst ? 32'(m_cnt0) : 32'd0);
        chk("gcnt1", 32'(gcnt1), rst ? 32'(m_cnt1) : 32'd0);
        @(posedge clk);
        if (!rst) begin
            m_last = 1; m_pend_valid = 0; m_pend_id = 0; m_pend_addr = 0;
            m_err = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_pend_valid = (w >= 0) ? 1 : 0;
            m_pend_id = (w == 1) ? 1 : 0;
            m_pend_addr = ea;
            if (w >= 0) begin
                m_last = w;
                if (ea >= DEPTH) m_err = 1;
            end
            if (w == 0 && m_cnt0 < 65535) m_cnt0++;
            if (w == 1 && m_cnt1 < 65535) m_cnt1++;
        end
        m_g0 = (w == 0) ? 1 : 0;
        m_g1 = (w == 1) ? 1 : 0;
        #1;
    endtask

    initial begin
        logic r0, r1;
        logic [AW-1:0] a0, a1;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

        // Reset phase
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 9'd5, 9'd6);

        // Single request from requester 0
        step(1'b1, 1'b1, 1'b0, 9'd5, 9'd0);
        step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
        chk("gcnt0_after_one", 32'(gcnt0), 32'd1);

        // Both requesters held for four cycles
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 9'd10, 9'd20);
        step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);

        // Out-of-range request from requester 1
        step(1'b1, 1'b0, 1'b1, 9'd0, 9'd300);
        step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
        chk("err_oob_sticky", 32'(err_oob), 32'd1);
        step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);

        // Alternating grants to the lowest and highest valid addresses
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 9'd0, 9'd0);
            step(1'b1, 1'b0, 1'b1, 9'd0, 9'd271);
        end
        step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);

        // Reset one cycle after a grant suppresses the response
        step(1'b1, 1'b1, 1'b0, 9'd7, 9'd0);
        step(1'b0, 1'b0, 1'b0, 9'd0, 9'd0);
        step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
        chk("gcnt0_post_reset", 32'(gcnt0), 32'd0);
        chk("err_post_reset", 32'(err_oob), 32'd0);

        // Random traffic. A request that was not granted is held with the same address.
        r0 = 1'b0; r1 = 1'b0; a0 = '0; a1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(r0 && m_g0 == 0)) begin
                r0 = 1'($urandom_range(0, 1));
                a0 = AW'($urandom_range(0, 320));
            end
            if (!(r1 && m_g1 == 0)) begin
                r1 = 1'($urandom_range(0, 1));
                a1 = AW'($urandom_range(0, 320));
            end
            step(($urandom_range(0, 40) != 0), r0, r1, a0, a1);
        end

        // Saturation run for requester 0
        step(1'b0, 1'b0, 1'b0, 9'd0, 9'd0);
        for (int i = 0; i < 70000; i++) step(1'b1, 1'b1, 1'b0, AW'($urandom_range(0, DEPTH - 1)), 9'd0);
        step(1'b1, 1'b0, 1'b0, 9'd0, 9'd0);
        chk("gcnt0_saturated", 32'(gcnt0), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
